// File: rtl/fp_div_pkg.sv
// Shared types and constants for the sequential floating-point divider.
package fp_div_pkg;

  typedef enum logic [1:0] {IDLE, DIV, ROUND} state_t;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} op_class_t;

  // Widest operand format the helper functions can build constants for.
  localparam int MAX_W = 128;

  function automatic int exp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN {0, all-ones exponent, 1, zeros}, LSB-aligned in MAX_W bits.
  function automatic logic [MAX_W-1:0] qnan_bits(input int exp_w, input int man_w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < exp_w; i++) r[man_w + i] = 1'b1;
    r[man_w - 1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fp_div_classify.sv
// Splits one operand into sign, exponent and significand and tags its class.
// Denormals (exponent 0) are treated as zero.
module fp_div_classify
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] op,
  output logic                 sign,
  output logic [EXP_W-1:0]     expo,
  output logic [MAN_W:0]       sig,
  output op_class_t            cls
);

  // Field extraction and class decode from the exponent/fraction patterns.
  always_comb begin
    sign = op[EXP_W+MAN_W];
    expo = op[EXP_W+MAN_W-1:MAN_W];
    sig  = {1'b1, op[MAN_W-1:0]};
    cls  = NORM;
    if (expo == '0) begin
      cls = ZERO;
    end else if (&expo) begin
      cls = (op[MAN_W-1:0] == '0) ? INF : NAN;
    end
  end

endmodule

// File: rtl/fp_div_seq.sv
// Sequential radix-2 restoring divider q = y / x with round-to-nearest-even,
// special-operand shortcuts and exception flags. One division at a time.
module fp_div_seq
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [EXP_W+MAN_W:0] y,
  input  logic [EXP_W+MAN_W:0] x,
  output logic                 busy,
  output logic                 done,
  output logic [EXP_W+MAN_W:0] q,
  output logic                 flag_inv,
  output logic                 flag_dz,
  output logic                 flag_ovf,
  output logic                 flag_unf
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int CW = $clog2(MAN_W + 3);
  localparam logic [CW-1:0]          LAST_CNT  = CW'(MAN_W + 2);
  localparam logic signed [EXP_W+1:0] BIAS     = (EXP_W+2)'(exp_bias(EXP_W));
  localparam logic signed [EXP_W+1:0] EXP_SAT  = (EXP_W+2)'((1 << EXP_W) - 1);
  localparam logic signed [EXP_W+1:0] ONE_E    = (EXP_W+2)'(1);
  localparam logic signed [EXP_W+1:0] E_ZERO   = '0;
  localparam logic [MAX_W-1:0]        QNAN_WIDE = qnan_bits(EXP_W, MAN_W);
  localparam logic [W-1:0]            QNAN      = QNAN_WIDE[W-1:0];

  logic             sy, sx;
  logic [EXP_W-1:0] ey, ex;
  logic [MAN_W:0]   my, mx;
  op_class_t        cy, cx;

  fp_div_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_y (
    .op(y), .sign(sy), .expo(ey), .sig(my), .cls(cy)
  );

  fp_div_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_x (
    .op(x), .sign(sx), .expo(ex), .sig(mx), .cls(cx)
  );

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [MAN_W+1:0]        a, b;
  logic [MAN_W+2:0]        qbits;
  logic signed [EXP_W+1:0] exp_diff;
  logic                    sign_r;

  logic                    rsign;
  logic signed [EXP_W+1:0] exp_diff_n;

  assign rsign      = sy ^ sx;
  assign exp_diff_n = $signed({2'b00, ey}) - $signed({2'b00, ex});

  // Decide whether the operand pair short-circuits the iteration and what it yields.
  logic         special, spec_inv, spec_dz;
  logic [W-1:0] spec_q;
  always_comb begin
    special  = 1'b1;
    spec_inv = 1'b0;
    spec_dz  = 1'b0;
    spec_q   = '0;
    if (cy == NAN || cx == NAN || (cy == ZERO && cx == ZERO) || (cy == INF && cx == INF)) begin
      spec_q   = QNAN;
      spec_inv = 1'b1;
    end else if (cy == INF) begin
      spec_q = {rsign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (cx == ZERO) begin
      spec_q  = {rsign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      spec_dz = 1'b1;
    end else if (cy == ZERO || cx == INF) begin
      spec_q = {rsign, {(W-1){1'b0}}};
    end else begin
      special = 1'b0;
    end
  end

  // One restoring step: trial subtract, keep or discard, then shift the remainder.
  logic [MAN_W+2:0] diff;
  logic             qbit_next;
  logic [MAN_W+1:0] rem, a_next;
  always_comb begin
    diff      = {1'b0, a} - {1'b0, b};
    qbit_next = ~diff[MAN_W+2];
    rem       = qbit_next ? diff[MAN_W+1:0] : a;
    a_next    = rem << 1;
  end

  // Normalise the raw quotient, round to nearest even and range-check the exponent.
  logic                    norm, guard, sticky, inc;
  logic [MAN_W:0]          sig;
  logic [MAN_W+1:0]        sig_r;
  logic [MAN_W-1:0]        frac;
  logic signed [EXP_W+1:0] e_pre, e_fin;
  logic [W-1:0]            rnd_q;
  logic                    rnd_ovf, rnd_unf;
  always_comb begin
    norm    = qbits[MAN_W+2];
    sig     = norm ? qbits[MAN_W+2:2] : qbits[MAN_W+1:1];
    guard   = norm ? qbits[1] : qbits[0];
    sticky  = (norm & qbits[0]) | (|a);
    e_pre   = norm ? (exp_diff + BIAS) : (exp_diff + BIAS - ONE_E);
    inc     = guard & (sticky | sig[0]);
    sig_r   = {1'b0, sig} + {{(MAN_W+1){1'b0}}, inc};
    // A carry-out leaves the low bits all zero, which is exactly 1.0.
    frac    = sig_r[MAN_W] ? sig_r[MAN_W-1:0] : '0;
    e_fin   = e_pre + $signed({{(EXP_W+1){1'b0}}, sig_r[MAN_W+1]});
    rnd_ovf = 1'b0;
    rnd_unf = 1'b0;
    if (e_fin >= EXP_SAT) begin
      rnd_q   = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      rnd_ovf = 1'b1;
    end else if (e_fin <= E_ZERO) begin
      rnd_q   = {sign_r, {(W-1){1'b0}}};
      rnd_unf = 1'b1;
    end else begin
      rnd_q = {sign_r, e_fin[EXP_W-1:0], frac};
    end
  end

  // Control FSM with registered handshake, result and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      a        <= '0;
      b        <= '0;
      qbits    <= '0;
      exp_diff <= '0;
      sign_r   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      q        <= '0;
      flag_inv <= 1'b0;
      flag_dz  <= 1'b0;
      flag_ovf <= 1'b0;
      flag_unf <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            flag_inv <= 1'b0;
            flag_dz  <= 1'b0;
            flag_ovf <= 1'b0;
            flag_unf <= 1'b0;
            if (special) begin
              q        <= spec_q;
              flag_inv <= spec_inv;
              flag_dz  <= spec_dz;
              done     <= 1'b1;
            end else begin
              a        <= {1'b0, my};
              b        <= {1'b0, mx};
              qbits    <= '0;
              cnt      <= '0;
              exp_diff <= exp_diff_n;
              sign_r   <= rsign;
              busy     <= 1'b1;
              state    <= DIV;
            end
          end
        end
        DIV: begin
          qbits <= {qbits[MAN_W+1:0], qbit_next};
          a     <= a_next;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST_CNT) state <= ROUND;
        end
        ROUND: begin
          q        <= rnd_q;
          flag_ovf <= rnd_ovf;
          flag_unf <= rnd_unf;
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fp_div_seq.md
Name: fp_div_seq

Overview:
- Parametrised, sequential radix-2 restoring floating-point divider computing q = y / x on IEEE-754-style operands of configurable width.
- Successor to the FP calculator's single-precision divider. Adds a start/busy/done handshake, asynchronous reset, round-to-nearest-even with sticky, special-operand handling, and exception flags.
- Sits behind the calculator's operation decoder; one division in flight at a time.

Parameters:
EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
MAN_W, 23, stored fraction width (significand is MAN_W+1 bits with the hidden 1)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; accepted only when busy=0
y  in  1+EXP_W+MAN_W  dividend {sign, exp, frac}
x  in  1+EXP_W+MAN_W  divisor {sign, exp, frac}
busy  out  1  high from the accepting edge until the edge that raises done
done  out  1  one-cycle pulse; q and flags are valid from this cycle on
q  out  1+EXP_W+MAN_W  quotient; held until the next done
flag_inv  out  1  invalid operation (NaN operand, 0/0, inf/inf)
flag_dz  out  1  finite nonzero / zero
flag_ovf  out  1  result overflowed to infinity
flag_unf  out  1  result underflowed, flushed to zero

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, q and all flags = 0; iteration counter cleared. Asserting reset mid-division aborts it with no done.
- FSM states: IDLE, DIV, ROUND.
  - IDLE -> DIV on start (normal operands).
  - IDLE -> IDLE on start with special operands; the result is registered with done=1 on the next edge.
  - DIV -> ROUND after the counter reaches MAN_W+3.
  - ROUND -> IDLE with done=1.
- start while busy=1 is ignored. start in the done cycle is accepted, because the FSM is already in IDLE.
- Operand classification: exp=0 is treated as zero (denormal inputs flush to zero). exp all-ones with frac=0 is inf; exp all-ones with frac≠0 is NaN.
- Sign of every result, including specials other than NaN = y.sign ^ x.sign.
- Special results (latency 1 edge after accept):
  - NaN in, 0/0, or inf/inf: canonical qNaN {0, all-ones, 1, zeros}; flag_inv.
  - finite/0: signed inf; flag_dz.
  - inf/finite: signed inf.
  - 0/nonzero or finite/inf: signed zero.
- Normal path:
  - Load A = {01, frac_y} and B = {01, frac_x} (MAN_W+2 bits).
  - Each DIV cycle: D = A - B. If D ≥ 0, the quotient bit is 1 and A = 2·D; otherwise the bit is 0 and A = 2·A. Produce MAN_W+3 bits Q, MSB weight 2^0.
  - Sticky S = (final A ≠ 0).
- Normalise:
  - If Q[MAN_W+2]=1: significand = Q[MAN_W+2:2], guard = Q[1], sticky = Q[0]|S, e = Ey - Ex + bias.
  - Else: significand = Q[MAN_W+1:1], guard = Q[0], sticky = S, e = Ey - Ex + bias - 1.
- Exponent arithmetic is done signed in EXP_W+2 bits.
- Rounding: RNE. Increment if guard & (sticky | lsb). A significand carry-out sets the significand to 1.0 and e+1.
- Range after rounding:
  - e ≥ 2^EXP_W - 1: signed inf, flag_ovf.
  - e ≤ 0: signed zero, flag_unf.
- Latency, normal path: done rises MAN_W+4 edges after the accepting edge (27 for defaults).
- Flags are cleared on accept and updated at done; they are sticky only until the next accept.

Decomposition:
- Package fp_div_pkg holds:
  - state enum (IDLE, DIV, ROUND);
  - functions for bias and the qNaN constant, parametrised by EXP_W/MAN_W;
  - operand-class enum (ZERO, NORM, INF, NAN).
- One sub-module, fp_div_classify: purely combinational. Per operand it outputs sign, exp, significand with hidden bit, and class. It is instantiated twice.

Test Plan:
- y=0x40C00000 (6.0), x=0x40000000 (2.0) -> q=0x40400000, flags 0, done exactly 27 edges after accept, busy high throughout.
- y=0x3F800000 (1.0), x=0x40400000 (3.0) -> q=0x3EAAAAAB (RNE round-up). Also y=0xC0C00000 (-6.0), x=0x40000000 (2.0) -> q=0xC0400000.
- Specials: y=0x3F800000, x=0x00000000 -> 0x7F800000 with flag_dz. y=0, x=0 -> 0x7FC00000 with flag_inv. Each has done one edge after accept.
- y=0x7F7FFFFF, x=0x3F000000 -> 0x7F800000 with flag_ovf. y=0x00800000, x=0x4B000000 -> 0x00000000 with flag_unf.
- Start pulsed at cycle 5 of a division -> ignored, first result unchanged. Start in the done cycle -> accepted, second done 27 edges later.
- rst_n low at cycle 10 of a division -> busy, done, q and flags go to 0 immediately; no done follows. A new start after release completes normally.
